// File: rtl/des_pkg.sv
// ============================================================================
//  des_pkg : shared DES key-schedule constants, PC1 and C/D rotation helpers
//  Rev 1.0
// ============================================================================
`default_nettype none

package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_ENC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    // Left-rotation amount for rounds 1..16
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Bit n of the FIPS numbering lives at vector index (width - n).
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[55-j] = key[64-PC1_TAB[j]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input dir_e dir,
                                          input logic [1:0] n);
        logic [27:0] r;
        if (dir == DIR_ENC) begin
            r = (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        end else begin
            r = (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        end
        return r;
    endfunction

    function automatic logic [55:0] cd_rotate(input logic [55:0] cd, input dir_e dir,
                                              input logic [1:0] n);
        return {rot28(cd[55:28], dir, n), rot28(cd[27:0], dir, n)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2.sv
// ============================================================================
//  des_pc2 : DES permuted choice 2, 56-bit C/D to 48-bit subkey
//  Rev 1.0
// ============================================================================
`default_nettype none

module des_pc2 (
    input  logic [55:0] cd_i,
    output logic [47:0] sk_o
);

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    always_comb begin
        sk_o = '0;
        for (int j = 0; j < 48; j++) begin
            sk_o[47-j] = cd_i[56-PC2_TAB[j]];
        end
    end

endmodule

`default_nettype wire

// File: rtl/des_key_sched.sv
// ============================================================================
//  des_key_sched : streaming DES / 3DES subkey generator, one subkey per cycle
//  Rev 1.0
// ============================================================================
`default_nettype none

module des_key_sched
    import des_pkg::*;
#(
    parameter int NUM_KEYS  = 1,
    parameter int OUT_IDX_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [64*NUM_KEYS-1:0]   key_in,
    input  logic                     decrypt,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic                     flush,
    output logic [47:0]              sk_out,
    output logic [OUT_IDX_W-1:0]     sk_idx,
    output logic                     sk_last,
    output logic                     sk_valid,
    input  logic                     sk_ready,
    output logic                     busy
);

    localparam logic [1:0]           LAST_PASS = 2'(NUM_KEYS - 1);
    localparam logic [OUT_IDX_W-1:0] IDX_ONE   = OUT_IDX_W'(1);

    state_e                  state_q;
    logic [64*NUM_KEYS-1:0]  keys_q;
    logic                    dec_q;
    logic [55:0]             cd_q,     cd_d;
    logic [3:0]              round_q,  round_d;
    logic [1:0]              pass_q,   pass_d;
    logic [OUT_IDX_W-1:0]    idx_q;
    logic [47:0]             sk_out_q;
    logic                    sk_valid_q;
    logic                    sk_last_q, sk_last_d;
    logic                    key_ready_q;
    logic                    load, adv;
    logic [47:0]             pc2_sk;
    dir_e                    cur_dir;

    // Odd passes of a 3DES job run opposite to the job direction.
    function automatic dir_e pass_dir(input logic dec, input logic [1:0] pass);
        return dir_e'(dec ^ pass[0]);
    endfunction

    function automatic logic [55:0] pass_start(input logic [64*NUM_KEYS-1:0] keys,
                                               input logic dec, input logic [1:0] pass);
        logic [1:0]  kidx;
        logic [63:0] k;
        logic [55:0] cd;
        kidx = dec ? (LAST_PASS - pass) : pass;
        k    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (kidx == 2'(i)) k = keys[64*(NUM_KEYS-i)-1 -: 64];
        end
        cd = pc1(k);
        if (pass_dir(dec, pass) == DIR_ENC) cd = cd_rotate(cd, DIR_ENC, SHIFT_SCHED[0]);
        return cd;
    endfunction

    always_comb begin
        load      = (state_q == ST_IDLE) && key_valid && key_ready_q;
        adv       = (state_q == ST_RUN) && sk_valid_q && sk_ready;
        cur_dir   = pass_dir(dec_q, pass_q);
        cd_d      = cd_q;
        round_d   = round_q;
        pass_d    = pass_q;
        if (load) begin
            cd_d    = pass_start(key_in, decrypt, 2'd0);
            round_d = 4'd0;
            pass_d  = 2'd0;
        end else if (adv && !sk_last_q && (round_q == 4'd15)) begin
            cd_d    = pass_start(keys_q, dec_q, pass_q + 2'd1);
            round_d = 4'd0;
            pass_d  = pass_q + 2'd1;
        end else if (adv && !sk_last_q) begin
            // Decrypt walks the schedule backwards: right-rotate by the amount of the round being undone.
            cd_d    = cd_rotate(cd_q, cur_dir,
                                (cur_dir == DIR_ENC) ? SHIFT_SCHED[round_q + 4'd1]
                                                     : SHIFT_SCHED[4'd15 - round_q]);
            round_d = round_q + 4'd1;
        end
        sk_last_d = (round_d == 4'd15) && (pass_d == LAST_PASS);
    end

    des_pc2 u_pc2 (
        .cd_i (cd_d),
        .sk_o (pc2_sk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            keys_q      <= '0;
            dec_q       <= 1'b0;
            cd_q        <= '0;
            round_q     <= '0;
            pass_q      <= '0;
            idx_q       <= '0;
            sk_out_q    <= '0;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            key_ready_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    key_ready_q <= 1'b1;
                    if (load) begin
                        state_q     <= ST_RUN;
                        key_ready_q <= 1'b0;
                        keys_q      <= key_in;
                        dec_q       <= decrypt;
                        cd_q        <= cd_d;
                        round_q     <= round_d;
                        pass_q      <= pass_d;
                        idx_q       <= '0;
                        sk_out_q    <= pc2_sk;
                        sk_valid_q  <= 1'b1;
                        sk_last_q   <= sk_last_d;
                    end
                end
                ST_RUN: begin
                    if (adv && sk_last_q) begin
                        state_q     <= ST_IDLE;
                        idx_q       <= '0;
                        sk_valid_q  <= 1'b0;
                        sk_last_q   <= 1'b0;
                        key_ready_q <= 1'b1;
                    end else if (adv) begin
                        cd_q        <= cd_d;
                        round_q     <= round_d;
                        pass_q      <= pass_d;
                        idx_q       <= idx_q + IDX_ONE;
                        sk_out_q    <= pc2_sk;
                        sk_last_q   <= sk_last_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign sk_out    = sk_out_q;
    assign sk_idx    = idx_q;
    assign sk_last   = sk_last_q;
    assign sk_valid  = sk_valid_q;
    assign busy      = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_des_key_sched.sv
// ============================================================================
//  tb_des_key_sched : scoreboard bench for single-DES and 3DES key schedules
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_des_key_sched;

    typedef struct packed {
        logic [47:0] sk;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [47:0] SK_K1 = 48'h1B02EFFC7072;
    localparam logic [47:0] SK_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // Total left rotation applied before round r subkey
    localparam int CUM_T [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  key1;   logic [191:0] key3;
    logic         dec1, kv1, kr1, fl1, last1, v1, rdy1, busy1;
    logic         dec3, kv3, kr3, fl3, last3, v3, rdy3, busy3;
    logic [47:0]  sk1, sk3;
    logic [5:0]   idx1, idx3;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc1, start_cyc3, last_cyc1, last_cyc3;
    logic bp1 = 1'b0;
    exp_t sb1[$], sb3[$];
    logic [47:0] obs1 [64];
    logic [47:0] obs3 [64];

    des_key_sched #(.NUM_KEYS(1), .OUT_IDX_W(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key1), .decrypt(dec1),
        .key_valid(kv1), .key_ready(kr1), .flush(fl1),
        .sk_out(sk1), .sk_idx(idx1), .sk_last(last1),
        .sk_valid(v1), .sk_ready(rdy1), .busy(busy1)
    );

    des_key_sched #(.NUM_KEYS(3), .OUT_IDX_W(6)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .key_in(key3), .decrypt(dec3),
        .key_valid(kv3), .key_ready(kr3), .flush(fl3),
        .sk_out(sk3), .sk_idx(idx3), .sk_last(last3),
        .sk_valid(v3), .sk_ready(rdy3), .busy(busy3)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin @(posedge clk); #1; if (bp1) rdy1 = 1'($urandom_range(0, 1)); end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] ref_sk(input logic [63:0] key, input int round);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] r;
        for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1_T[j]];
        c = cd[55:28];
        d = cd[27:0];
        for (int s = 0; s < CUM_T[round]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_T[j]];
        return r;
    endfunction

    task automatic push_job(input int which, input logic [191:0] keys, input int nk, input logic dec);
        exp_t        e;
        logic [63:0] k;
        logic        d;
        int          ki;
        int          n = 0;
        for (int p = 0; p < nk; p++) begin
            ki = dec ? nk - 1 - p : p;
            k  = keys[64*(nk-ki)-1 -: 64];
            d  = dec ^ (p == 1);
            for (int r = 0; r < 16; r++) begin
                e.sk   = ref_sk(k, d ? 15 - r : r);
                e.idx  = 6'(n);
                e.last = (n == 16*nk - 1);
                n++;
                if (which == 1) sb1.push_back(e);
                else            sb3.push_back(e);
            end
        end
    endtask

    task automatic start1(input logic [63:0] k, input logic d);
        check("kr1_before_load", {63'd0, kr1}, 64'd1);
        key1 = k; dec1 = d; kv1 = 1'b1;
        for (int i = 0; i < 64; i++) obs1[i] = '1;
        push_job(1, {128'd0, k}, 1, d);
        @(posedge clk); #1;
        kv1 = 1'b0;
        start_cyc1 = cyc;
        check("busy1_after_load", {63'd0, busy1}, 64'd1);
    endtask

    task automatic start3(input logic [191:0] k, input logic d);
        check("kr3_before_load", {63'd0, kr3}, 64'd1);
        key3 = k; dec3 = d; kv3 = 1'b1;
        for (int i = 0; i < 64; i++) obs3[i] = '1;
        push_job(3, k, 3, d);
        @(posedge clk); #1;
        kv3 = 1'b0;
        start_cyc3 = cyc;
    endtask

    task automatic drain(input int which, input int budget);
        int n = 0;
        while (((which == 1) ? sb1.size() : sb3.size()) != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) check("drain_timeout", 64'((which == 1) ? sb1.size() : sb3.size()), 64'd0);
    endtask

    // Monitors: pop on every handshake, and hold-check the cycle after a stall.
    initial begin
        exp_t        e;
        logic        stall = 1'b0;
        logic [55:0] held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("stall_hold1", {8'd0, v1, last1, idx1, sk1}, {8'd0, held});
                if (v1 && rdy1) begin
                    if (sb1.size() == 0) check("sb1_underflow", 64'(sb1.size()), 64'd1);
                    else begin
                        e = sb1.pop_front();
                        check("sk1", {16'd0, sk1}, {16'd0, e.sk});
                        check("idx1", {58'd0, idx1}, {58'd0, e.idx});
                        check("last1", {63'd0, last1}, {63'd0, e.last});
                        obs1[idx1] = sk1;
                        last_cyc1  = cyc;
                    end
                end
                stall = v1 && !rdy1;
                held  = {v1, last1, idx1, sk1};
            end
        end
    end

    initial begin
        exp_t        e;
        logic        stall = 1'b0;
        logic [55:0] held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("stall_hold3", {8'd0, v3, last3, idx3, sk3}, {8'd0, held});
                if (v3 && rdy3) begin
                    if (sb3.size() == 0) check("sb3_underflow", 64'(sb3.size()), 64'd1);
                    else begin
                        e = sb3.pop_front();
                        check("sk3", {16'd0, sk3}, {16'd0, e.sk});
                        check("idx3", {58'd0, idx3}, {58'd0, e.idx});
                        check("last3", {63'd0, last3}, {63'd0, e.last});
                        obs3[idx3] = sk3;
                        last_cyc3  = cyc;
                    end
                end
                stall = v3 && !rdy3;
                held  = {v3, last3, idx3, sk3};
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        key1 = '0; dec1 = 0; kv1 = 0; fl1 = 0; rdy1 = 1;
        key3 = '0; dec3 = 0; kv3 = 0; fl3 = 0; rdy3 = 1;
        repeat (2) @(posedge clk);
        #3;
        check("rst_outs1", {7'd0, v1, kr1, busy1, last1, idx1, sk1}, 64'd0);
        check("rst_outs3", {7'd0, v3, kr3, busy3, last3, idx3, sk3}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("kr1_held_low", {63'd0, kr1}, 64'd0);
        @(posedge clk); #1;
        check("kr1_after_rst", {63'd0, kr1}, 64'd1);
        check("kr3_after_rst", {63'd0, kr3}, 64'd1);

        // Test 1: single DES encrypt, full rate
        start1(KEY_A, 1'b0);
        drain(1, 40);
        check("t1_sk0", {16'd0, obs1[0]}, {16'd0, SK_K1});
        check("t1_sk15", {16'd0, obs1[15]}, {16'd0, SK_K16});
        check("t1_span", 64'(last_cyc1 - start_cyc1), 64'd15);
        check("t1_idle", {62'd0, v1, kr1}, 64'd1);
        check("t1_busy", {63'd0, busy1}, 64'd0);

        // Test 2: single DES decrypt
        start1(KEY_A, 1'b1);
        drain(1, 40);
        check("t2_sk0", {16'd0, obs1[0]}, {16'd0, SK_K16});
        check("t2_sk15", {16'd0, obs1[15]}, {16'd0, SK_K1});

        // Test 3: 3DES encrypt with a zero middle key, then random-key decrypt
        start3({KEY_A, 64'd0, KEY_A}, 1'b0);
        drain(3, 80);
        check("t3_sk0", {16'd0, obs3[0]}, {16'd0, SK_K1});
        for (int i = 16; i < 32; i++) check("t3_mid_zero", {16'd0, obs3[i]}, 64'd0);
        check("t3_sk47", {16'd0, obs3[47]}, {16'd0, SK_K16});
        check("t3_span", 64'(last_cyc3 - start_cyc3), 64'd47);
        check("t3_idle", {62'd0, v3, kr3}, 64'd1);
        start3({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain(3, 80);

        // Test 4: random backpressure
        bp1 = 1'b1;
        start1(KEY_A, 1'b0);
        drain(1, 400);
        bp1 = 1'b0; rdy1 = 1'b1;
        check("t4_sk0", {16'd0, obs1[0]}, {16'd0, SK_K1});
        check("t4_sk15", {16'd0, obs1[15]}, {16'd0, SK_K16});
        @(posedge clk); #1;

        // Test 5: flush while subkey 7 is presented
        start1({$urandom, $urandom}, 1'b0);
        n = 0;
        while (!(v1 && idx1 == 6'd7) && n < 40) begin @(posedge clk); #1; n++; end
        check("t5_reach_idx7", {58'd0, idx1}, 64'd7);
        fl1 = 1'b1;
        @(posedge clk); #1;
        fl1 = 1'b0;
        sb1.delete();
        check("t5_flush_state", {55'd0, v1, kr1, busy1, idx1}, {55'd0, 1'b0, 1'b1, 1'b0, 6'd0});
        start1(KEY_A, 1'b0);
        drain(1, 40);
        check("t5_restart_sk0", {16'd0, obs1[0]}, {16'd0, SK_K1});

        // Test 6: asynchronous reset mid-job
        start1(KEY_A, 1'b1);
        start3({KEY_A, ~KEY_A, KEY_A}, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs1", {7'd0, v1, kr1, busy1, last1, idx1, sk1}, 64'd0);
        check("t6_rst_outs3", {7'd0, v3, kr3, busy3, last3, idx3, sk3}, 64'd0);
        sb1.delete();
        sb3.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_kr1", {63'd0, kr1}, 64'd1);
        check("t6_kr3", {63'd0, kr3}, 64'd1);
        start1(KEY_A, 1'b0);
        drain(1, 40);
        check("t6_after_sk15", {16'd0, obs1[15]}, {16'd0, SK_K16});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 1, number of 64-bit DES keys per job; legal values 1 (single DES) and 3 (3DES EDE).
REQ-002 SHALL have parameter OUT_IDX_W, default 6, width of sk_idx; must hold 16*NUM_KEYS-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port key_in, input, 64*NUM_KEYS bits, keys K1..Kn with K1 in the MSBs; within each key, bit 1 is the MSB (FIPS numbering); parity bits are ignored.
REQ-006 SHALL have port decrypt, input, 1 bit, job direction, sampled with the key.
REQ-007 SHALL have port key_valid, input, 1 bit, and port key_ready, output, 1 bit, forming the job-load handshake.
REQ-008 SHALL have port flush, input, 1 bit, synchronous abort.
REQ-009 SHALL have port sk_out, output, 48 bits, the current subkey, PC2 order, bit 1 = MSB.
REQ-010 SHALL have port sk_idx, output, OUT_IDX_W bits, subkey sequence number within the job, starting at 0.
REQ-011 SHALL have port sk_last, output, 1 bit, high on the final subkey of the job.
REQ-012 SHALL have ports sk_valid, output, 1 bit, and sk_ready, input, 1 bit, forming the subkey handshake.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE and RUN. key_ready SHALL be 1 only in IDLE.
REQ-015 IDLE->RUN SHALL occur on key_valid&key_ready: capture key_in and decrypt, load C/D = PC1(first key of the pass order), and present subkey 0 with sk_valid=1 on the next cycle (latency 1).
REQ-016 Pass order SHALL be as follows:
- NUM_KEYS=1: K1 in the job direction.
- NUM_KEYS=3, encrypt: K1 enc, K2 dec, K3 enc.
- NUM_KEYS=3, decrypt: K3 dec, K2 enc, K1 dec.
REQ-017 An enc pass SHALL emit PC2 of C/D after left rotations per round of 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (K1..K16).
REQ-018 A dec pass SHALL emit K16..K1: first subkey PC2 of the unrotated PC1 output, then right rotations of 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before each subsequent subkey.
REQ-019 sk_out, sk_idx and sk_last SHALL hold stable while sk_valid&!sk_ready.
REQ-020 Each sk_valid&sk_ready SHALL advance to the next subkey on the next cycle, giving 1 subkey/cycle under constant sk_ready.
REQ-021 Between passes, PC1 of the next key SHALL be loaded with no bubble.
REQ-022 sk_idx SHALL increment by 1 per accepted subkey, reaching 16*NUM_KEYS-1 together with sk_last.
REQ-023 Acceptance of the sk_last subkey SHALL return the FSM to IDLE: sk_valid=0 and key_ready=1 the following cycle. A new job is never accepted in the same cycle as the last handshake.
REQ-024 flush=1 SHALL force IDLE next cycle from any state, drop sk_valid, and clear sk_idx; flush SHALL take priority over all handshakes in that cycle.
REQ-025 key_valid while RUN SHALL be ignored and has no effect.

Reset
REQ-026 rst_n low SHALL immediately set IDLE, sk_valid=0, sk_out=0, sk_idx=0, sk_last=0, busy=0, key_ready=0, and clear the key and C/D registers.
REQ-027 key_ready SHALL go to 1 on the first clk edge after rst_n deassertion.
REQ-028 Reset mid-job SHALL discard the job with no partial-output obligations.

Structure
REQ-029 A shared package des_pkg SHALL hold the 16-entry shift schedule, the PC1 function, the FSM state enum and the pass-direction type.
REQ-030 The existing des_pc2 SHALL be instantiated once as the sole sub-module, fed from the rotated C/D next-state so that sk_out is registered.

Verification
REQ-031 Test 1 SHALL cover NUM_KEYS=1, encrypt, key 133457799BBCDFF1, sk_ready=1 -> sk_idx 0 = 1B02EFFC7072, sk_idx 15 = CB3D8B0E17F5, sk_last on idx 15, 16 consecutive cycles.
REQ-032 Test 2 SHALL cover the same key with decrypt=1 -> idx 0 = CB3D8B0E17F5, idx 15 = 1B02EFFC7072.
REQ-033 Test 3 SHALL cover NUM_KEYS=3, encrypt, keys {133457799BBCDFF1, 0000000000000000, 133457799BBCDFF1} -> idx 0 = 1B02EFFC7072, idx 16..31 all 000000000000, idx 47 = CB3D8B0E17F5, sk_last only at 47.
REQ-034 Test 4 SHALL cover random sk_ready backpressure (about 50%) -> identical subkey sequence to Test 1, with outputs stable during every stall.
REQ-035 Test 5 SHALL cover flush asserted at idx 7 -> sk_valid=0 and key_ready=1 next cycle; a new job then restarts at idx 0 with the correct K1.
REQ-036 Test 6 SHALL cover rst_n pulsed low mid-job -> all outputs 0 asynchronously, and key_ready=1 one cycle after release.
